dmem_port_arbiter: RTL

//  Shares the single-port data RAM of the pipeline MEM stage between the CPU (mwmem/malu/mb path)
//  and an auxiliary requester (program loader / debug port). CPU has priority, bounded by a

---
 rtl/dmem_port_arbiter_pkg.sv | 23 ++
 rtl/dmem_port_arbiter_if.sv | 45 ++++
 rtl/dmem_port_arbiter_sat_counter.sv | 22 ++
 rtl/dmem_port_arbiter.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/dmem_port_arbiter_pkg.sv
// Shared types for the MEM-stage data RAM arbiter.
// State and winner encodings plus counter width helper.
package dmem_arb_pkg;

    localparam int ADDR_W_DEF = 5;
    localparam int IO_BIT_DEF = 7;

    typedef enum logic {
        ST_CPU   = 1'b0,
        ST_BURST = 1'b1
    } arb_state_t;

    typedef enum logic [1:0] {
        WIN_NONE = 2'd0,
        WIN_CPU  = 2'd1,
        WIN_AUX  = 2'd2
    } win_t;

    function automatic int cnt_w(input int max);
        return $clog2(max + 1);
    endfunction

endpackage

// File: rtl/dmem_port_arbiter_if.sv
// CPU, aux and RAM signal bundle of the data RAM arbiter.
// master = requesters plus RAM model, slave = arbiter.
interface dmem_port_arbiter_if #(
    parameter int ADDR_W = 5
);
    logic              cpu_rd;
    logic              cpu_wr;
    logic [31:0]       cpu_addr;
    logic [31:0]       cpu_wdata;
    logic              cpu_stall;
    logic [31:0]       cpu_rdata;

    logic              aux_req;
    logic              aux_we;
    logic              aux_lock;
    logic [ADDR_W-1:0] aux_addr;
    logic [31:0]       aux_wdata;
    logic              aux_gnt;
    logic              aux_rvalid;
    logic [31:0]       aux_rdata;

    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic              ram_we;
    logic [31:0]       ram_rdata;

    modport master (
        output cpu_rd, cpu_wr, cpu_addr, cpu_wdata,
        input  cpu_stall, cpu_rdata,
        output aux_req, aux_we, aux_lock, aux_addr, aux_wdata,
        input  aux_gnt, aux_rvalid, aux_rdata,
        input  ram_addr, ram_wdata, ram_we,
        output ram_rdata
    );

    modport slave (
        input  cpu_rd, cpu_wr, cpu_addr, cpu_wdata,
        output cpu_stall, cpu_rdata,
        input  aux_req, aux_we, aux_lock, aux_addr, aux_wdata,
        output aux_gnt, aux_rvalid, aux_rdata,
        output ram_addr, ram_wdata, ram_we,
        input  ram_rdata
    );

endinterface

// File: rtl/dmem_port_arbiter_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Used for aux starvation and burst beat counting.
module arb_sat_counter #(
    parameter int MAX = 4,
    parameter int W   = $clog2(MAX + 1)
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (!resetn || clr) begin
            cnt <= '0;
        end else if (inc && (cnt != W'(MAX))) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Single-port data RAM arbiter: CPU MEM stage vs aux requester.
// CPU priority with aux starvation bound and lockable aux bursts.
module dmem_port_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int IO_BIT       = IO_BIT_DEF,
    parameter int STARVE_LIMIT = 4,
    parameter int MAX_BURST    = 8
) (
    input logic                 clock,
    input logic                 resetn,
    dmem_port_arbiter_if.slave  bus
);

    localparam int SW = cnt_w(STARVE_LIMIT);
    localparam int BW = cnt_w(MAX_BURST);

    arb_state_t    state;
    arb_state_t    state_nx;
    win_t          win;
    logic          cpu_ram_req;
    logic          beat_inc;
    logic          beat_clr;
    logic          starve_inc;
    logic          starve_clr;
    logic [SW-1:0] starve_cnt;
    logic [BW-1:0] beat_cnt;
    logic          aux_rvalid;
    logic [31:0]   aux_rdata;
    logic          aux_rd_gnt;

    assign cpu_ram_req = (bus.cpu_rd | bus.cpu_wr) & ~bus.cpu_addr[IO_BIT];

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state <= ST_CPU;
        end else begin
            state <= state_nx;
        end
    end

    // A burst counts its entry beat, so beat MAX_BURST is granted
    // while beat_cnt == MAX_BURST-1 and closes the burst.
    always_comb begin
        win      = WIN_NONE;
        state_nx = state;
        beat_inc = 1'b0;
        beat_clr = 1'b0;
        if (!resetn) begin
            state_nx = ST_CPU;
            beat_clr = 1'b1;
        end else begin
            unique case (state)
                ST_CPU: begin
                    if (bus.aux_req &&
                        (!cpu_ram_req ||
                         (starve_cnt == SW'(STARVE_LIMIT)))) begin
                        win = WIN_AUX;
                        if (bus.aux_lock && (MAX_BURST > 1)) begin
                            state_nx = ST_BURST;
                            beat_inc = 1'b1;
                        end
                    end else if (cpu_ram_req) begin
                        win = WIN_CPU;
                    end
                end
                ST_BURST: begin
                    if (bus.aux_req) begin
                        win = WIN_AUX;
                    end
                    if (!bus.aux_req || !bus.aux_lock ||
                        (beat_cnt == BW'(MAX_BURST - 1))) begin
                        state_nx = ST_CPU;
                        beat_clr = 1'b1;
                    end else begin
                        beat_inc = 1'b1;
                    end
                end
                default: begin
                    state_nx = ST_CPU;
                    beat_clr = 1'b1;
                end
            endcase
        end
    end

    assign bus.aux_gnt   = (win == WIN_AUX);
    assign bus.cpu_stall = resetn & cpu_ram_req & (win != WIN_CPU);
    assign bus.cpu_rdata = bus.ram_rdata;

    always_comb begin
        bus.ram_addr  = '0;
        bus.ram_wdata = '0;
        bus.ram_we    = 1'b0;
        unique case (win)
            WIN_CPU: begin
                bus.ram_addr  = bus.cpu_addr[ADDR_W+1:2];
                bus.ram_wdata = bus.cpu_wdata;
                bus.ram_we    = bus.cpu_wr;
            end
            WIN_AUX: begin
                bus.ram_addr  = bus.aux_addr;
                bus.ram_wdata = bus.aux_wdata;
                bus.ram_we    = bus.aux_we;
            end
            default: ;
        endcase
    end

    assign starve_inc = bus.aux_req & ~bus.aux_gnt;
    assign starve_clr = ~bus.aux_req | bus.aux_gnt;

    arb_sat_counter #(
        .MAX (STARVE_LIMIT),
        .W   (SW)
    ) u_starve (
        .clk    (clock),
        .resetn (resetn),
        .clr    (starve_clr),
        .inc    (starve_inc),
        .cnt    (starve_cnt)
    );

    arb_sat_counter #(
        .MAX (MAX_BURST),
        .W   (BW)
    ) u_beat (
        .clk    (clock),
        .resetn (resetn),
        .clr    (beat_clr),
        .inc    (beat_inc),
        .cnt    (beat_cnt)
    );

    assign aux_rd_gnt = bus.aux_gnt & ~bus.aux_we;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            aux_rvalid <= 1'b0;
            aux_rdata  <= '0;
        end else begin
            aux_rvalid <= aux_rd_gnt;
            if (aux_rd_gnt) begin
                aux_rdata <= bus.ram_rdata;
            end
        end
    end

    assign bus.aux_rvalid = aux_rvalid;
    assign bus.aux_rdata  = aux_rdata;

endmodule
